// File: rtl/uart_pkg.sv
// Shared UART definitions: line-format encodings, transmitter state set and
// stop-length helper. Also used by the configurable receiver.
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    localparam logic [1:0] STOP_1   = 2'b00;
    localparam logic [1:0] STOP_15  = 2'b01;
    localparam logic [1:0] STOP_2   = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_BRK,
        ST_STOP
    } tx_state_e;

    // Stop-bit length in s_ticks; the unused code 11 is treated as two stop bits.
    function automatic int unsigned stop_ticks(input logic [1:0] cfg_stop,
                                               input int unsigned oversample);
        case (cfg_stop)
            STOP_1:  return oversample;
            STOP_15: return oversample + oversample / 2;
            default: return 2 * oversample;
        endcase
    endfunction

endpackage

// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter: 5..DMAX data bits, none/even/odd
// parity, 1/1.5/2 stop bits, break generation, ready/done handshake.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = 16,
    parameter int DMAX       = 9,
    parameter int BRK_BITS   = 13
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            s_tick,
    input  logic            tx_start,
    input  logic            tx_brk,
    input  logic [DMAX-1:0] din,
    input  logic [3:0]      cfg_dbits,
    input  logic [1:0]      cfg_parity,
    input  logic [1:0]      cfg_stop,
    output logic            tx_ready,
    output logic            tx_done_tick,
    output logic            tx
);

    // s counts ticks within one bit (stop may be up to two bit times long);
    // n counts data bits or break bit times, whichever is longer.
    localparam int SW = $clog2(2 * OVERSAMPLE);
    localparam int NW = $clog2((DMAX > BRK_BITS) ? DMAX : BRK_BITS);

    localparam logic [SW-1:0] BIT_LAST = SW'(OVERSAMPLE - 1);
    localparam logic [NW-1:0] BRK_LAST = NW'(BRK_BITS - 1);

    tx_state_e       state_q, state_d;
    logic [SW-1:0]   s_q, s_d;
    logic [NW-1:0]   n_q, n_d;
    logic [DMAX-1:0] data_q, data_d;
    logic [NW-1:0]   dlast_q, dlast_d;
    logic [1:0]      parity_q, parity_d;
    logic [1:0]      stop_q, stop_d;
    logic            par_q, par_d;
    logic            tx_q, tx_d;
    logic            ready_q, ready_d;
    logic            done_q, done_d;

    logic [3:0]      dbits_clamped;
    logic [SW-1:0]   stop_last;

    // Clamp the requested data width into the supported range.
    always_comb begin
        dbits_clamped = cfg_dbits;
        if (cfg_dbits < 4'd5) begin
            dbits_clamped = 4'd5;
        end else if (cfg_dbits > 4'(DMAX)) begin
            dbits_clamped = 4'(DMAX);
        end
        stop_last = SW'(stop_ticks(stop_q, OVERSAMPLE) - 1);
    end

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d  = state_q;
        s_d      = s_q;
        n_d      = n_q;
        data_d   = data_q;
        dlast_d  = dlast_q;
        parity_d = parity_q;
        stop_d   = stop_q;
        par_d    = par_q;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (tx_start && ready_q) begin
                    data_d   = din;
                    dlast_d  = NW'(dbits_clamped - 4'd1);
                    parity_d = (cfg_parity == 2'b11) ? PAR_NONE : cfg_parity;
                    stop_d   = tx_brk ? STOP_1 :
                               ((cfg_stop == 2'b11) ? STOP_2 : cfg_stop);
                    s_d      = '0;
                    n_d      = '0;
                    par_d    = 1'b0;
                    state_d  = tx_brk ? ST_BRK : ST_START;
                end
            end
            ST_START: begin
                if (s_tick) begin
                    if (s_q == BIT_LAST) begin
                        s_d     = '0;
                        state_d = ST_DATA;
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            ST_DATA: begin
                if (s_tick) begin
                    if (s_q == BIT_LAST) begin
                        s_d    = '0;
                        par_d  = par_q ^ data_q[0];
                        data_d = data_q >> 1;
                        if (n_q == dlast_q) begin
                            n_d     = '0;
                            state_d = (parity_q != PAR_NONE) ? ST_PARITY : ST_STOP;
                        end else begin
                            n_d = n_q + NW'(1);
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (s_tick) begin
                    if (s_q == BIT_LAST) begin
                        s_d     = '0;
                        state_d = ST_STOP;
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            ST_BRK: begin
                if (s_tick) begin
                    if (s_q == BIT_LAST) begin
                        s_d = '0;
                        if (n_q == BRK_LAST) begin
                            n_d     = '0;
                            state_d = ST_STOP;
                        end else begin
                            n_d = n_q + NW'(1);
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            ST_STOP: begin
                if (s_tick) begin
                    if (s_q == stop_last) begin
                        s_d     = '0;
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Line level follows the state being entered so tx is a pure register.
        case (state_d)
            ST_START, ST_BRK: tx_d = 1'b0;
            ST_DATA:          tx_d = data_d[0];
            ST_PARITY:        tx_d = par_d ^ (parity_q == PAR_ODD);
            default:          tx_d = 1'b1;
        endcase
        ready_d = (state_d == ST_IDLE);
    end

    // State and output registers; reset aborts any frame without a done tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            s_q      <= '0;
            n_q      <= '0;
            data_q   <= '0;
            dlast_q  <= '0;
            parity_q <= PAR_NONE;
            stop_q   <= STOP_1;
            par_q    <= 1'b0;
            tx_q     <= 1'b1;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            s_q      <= s_d;
            n_q      <= n_d;
            data_q   <= data_d;
            dlast_q  <= dlast_d;
            parity_q <= parity_d;
            stop_q   <= stop_d;
            par_q    <= par_d;
            tx_q     <= tx_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
        end
    end

    assign tx           = tx_q;
    assign tx_ready     = ready_q;
    assign tx_done_tick = done_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Self-checking bench for uart_tx_cfg: table vectors from the test plan,
// hand sequences for reset/hold, and randomized frames against a model.
module tb_uart_tx_cfg;

    localparam int OS   = 16;
    localparam int DMAX = 9;
    localparam int BRK  = 13;

    logic            clk = 1'b0;
    logic            reset;
    logic            s_tick;
    logic            tx_start;
    logic            tx_brk;
    logic [DMAX-1:0] din;
    logic [3:0]      cfg_dbits;
    logic [1:0]      cfg_parity;
    logic [1:0]      cfg_stop;
    logic            tx_ready;
    logic            tx_done_tick;
    logic            tx;

    int total = 0;
    int bad   = 0;
    int tick_pct = 75;

    logic exp_q[$];

    uart_tx_cfg #(.OVERSAMPLE(OS), .DMAX(DMAX), .BRK_BITS(BRK)) dut (
        .clk(clk), .reset(reset), .s_tick(s_tick), .tx_start(tx_start),
        .tx_brk(tx_brk), .din(din), .cfg_dbits(cfg_dbits),
        .cfg_parity(cfg_parity), .cfg_stop(cfg_stop), .tx_ready(tx_ready),
        .tx_done_tick(tx_done_tick), .tx(tx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [8:0] d;
        logic [3:0] db;
        logic [1:0] par;
        logic [1:0] stp;
        logic       brk;
        int         ticks;
        bit         noise;
    } vec_t;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Reference: line level for every s_tick of the frame, from the frame rules.
    function automatic void build(input logic [8:0] d, input logic [3:0] db,
                                  input logic [1:0] p, input logic [1:0] st,
                                  input logic brk);
        int nb;
        int sl;
        logic ones;
        exp_q.delete();
        if (brk) begin
            for (int i = 0; i < BRK * OS; i++) exp_q.push_back(1'b0);
            for (int i = 0; i < OS; i++) exp_q.push_back(1'b1);
            return;
        end
        nb = (db < 5) ? 5 : ((db > DMAX) ? DMAX : int'(db));
        for (int i = 0; i < OS; i++) exp_q.push_back(1'b0);
        ones = 1'b0;
        for (int b = 0; b < nb; b++) begin
            for (int i = 0; i < OS; i++) exp_q.push_back(d[b]);
            ones = ones ^ d[b];
        end
        if (p == 2'b01) for (int i = 0; i < OS; i++) exp_q.push_back(ones);
        if (p == 2'b10) for (int i = 0; i < OS; i++) exp_q.push_back(~ones);
        sl = (st == 2'b00) ? OS : ((st == 2'b01) ? (OS * 3) / 2 : 2 * OS);
        for (int i = 0; i < sl; i++) exp_q.push_back(1'b1);
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge after done.
    task automatic run_frame(input logic [8:0] d, input logic [3:0] db,
                             input logic [1:0] p, input logic [1:0] st,
                             input logic brk, input int exp_ticks,
                             input bit noise, input string tag);
        int  k;
        int  cyc;
        int  first_bad;
        bit  got_done;
        build(d, db, p, st, brk);
        check({tag, "_ready_pre"}, int'(tx_ready), 1);
        din = d; cfg_dbits = db; cfg_parity = p; cfg_stop = st; tx_brk = brk;
        tx_start = 1'b1;
        s_tick = 1'($urandom_range(0, 1));
        @(negedge clk);
        check({tag, "_accept_tx_ready"}, int'({tx, tx_ready}), 0);
        k = 0; cyc = 0; first_bad = -1; got_done = 1'b0;
        while (cyc < 5000) begin
            if (noise) begin
                tx_start   = ($urandom_range(0, 9) == 0);
                din        = 9'($urandom);
                cfg_dbits  = 4'($urandom);
                cfg_parity = 2'($urandom);
                cfg_stop   = 2'($urandom);
                tx_brk     = 1'($urandom);
            end else begin
                tx_start = 1'b0;
            end
            s_tick = ($urandom_range(0, 99) < tick_pct);
            @(negedge clk);
            cyc++;
            if (s_tick) k++;
            if (tx_done_tick) begin
                got_done = 1'b1;
                break;
            end
            if (k >= exp_q.size()) break;
            if ((tx !== exp_q[k] || tx_ready !== 1'b0) && first_bad < 0) first_bad = k;
        end
        tx_start = 1'b0;
        s_tick   = 1'b0;
        check({tag, "_wave_first_bad_tick"}, first_bad, -1);
        check({tag, "_done_at_tick"}, got_done ? k : -1, exp_ticks);
        check({tag, "_done_tx_ready"}, got_done ? int'({tx, tx_ready}) : 0, 3);
        $display("frame %s din=%03h dbits=%0d par=%0d stop=%0d brk=%0d ticks=%0d done=%0d",
                 tag, d, db, p, st, brk, k, got_done);
    endtask

    vec_t tbl[7];

    initial begin
        int hold_bad;
        int k;
        int cnt_done;
        int cnt_low;

        tbl[0] = '{9'h055, 4'd8,  2'd0, 2'd0, 1'b0, 160, 1'b0};
        tbl[1] = '{9'h1C1, 4'd7,  2'd1, 2'd2, 1'b0, 176, 1'b0};
        tbl[2] = '{9'h1FF, 4'd9,  2'd2, 2'd1, 1'b0, 200, 1'b0};
        tbl[3] = '{9'h0A5, 4'd8,  2'd0, 2'd0, 1'b1, 224, 1'b0};
        tbl[4] = '{9'h055, 4'd8,  2'd0, 2'd0, 1'b0, 160, 1'b1};
        tbl[5] = '{9'h0F0, 4'd3,  2'd3, 2'd3, 1'b0, 128, 1'b0};
        tbl[6] = '{9'h123, 4'd15, 2'd1, 2'd0, 1'b0, 192, 1'b0};

        reset = 1'b1; s_tick = 1'b0; tx_start = 1'b0; tx_brk = 1'b0;
        din = '0; cfg_dbits = 4'd8; cfg_parity = 2'd0; cfg_stop = 2'd0;
        repeat (3) @(negedge clk);
        check("reset_tx_ready_done", int'({tx, tx_ready, tx_done_tick}), 6);
        reset = 1'b0;
        @(negedge clk);

        // Test-plan vectors, chained back-to-back: each starts in the done cycle.
        for (int i = 0; i < 7; i++) begin
            run_frame(tbl[i].d, tbl[i].db, tbl[i].par, tbl[i].stp, tbl[i].brk,
                      tbl[i].ticks, tbl[i].noise, $sformatf("tbl%0d", i));
        end

        // Hold without s_tick, then reset at tick 70 of an 8N1 frame.
        din = 9'h055; cfg_dbits = 4'd8; cfg_parity = 2'd0; cfg_stop = 2'd0;
        tx_brk = 1'b0; tx_start = 1'b1; s_tick = 1'b0;
        @(negedge clk);
        tx_start = 1'b0;
        hold_bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tx !== 1'b0 || tx_ready !== 1'b0) hold_bad++;
        end
        check("hold_no_tick_bad_cycles", hold_bad, 0);
        k = 0;
        s_tick = 1'b1;
        while (k < 70) begin
            @(negedge clk);
            k++;
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("reset_abort_tx_ready_done", int'({tx, tx_ready, tx_done_tick}), 6);
        cnt_done = 0; cnt_low = 0;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (tx_done_tick) cnt_done++;
            if (!tx) cnt_low++;
        end
        s_tick = 1'b0;
        check("reset_abort_no_done", cnt_done, 0);
        check("reset_abort_line_idle", cnt_low, 0);
        run_frame(9'h055, 4'd8, 2'd0, 2'd0, 1'b0, 160, 1'b0, "post_reset");

        // Randomized frames with random tick density, noise and idle gaps.
        for (int i = 0; i < 24; i++) begin
            logic [8:0] rd;
            logic [3:0] rdb;
            logic [1:0] rp;
            logic [1:0] rs;
            logic       rb;
            rd  = 9'($urandom);
            rdb = 4'($urandom);
            rp  = 2'($urandom);
            rs  = 2'($urandom);
            rb  = ($urandom_range(0, 7) == 0);
            tick_pct = $urandom_range(25, 100);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            build(rd, rdb, rp, rs, rb);
            run_frame(rd, rdb, rp, rs, rb, exp_q.size(), 1'($urandom),
                      $sformatf("rnd%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
